// File: rtl/clock_pkg.sv
// Shared clock-datapath types and constants: used by the seconds counter,
// the seconds-to-BCD converter and the 7-segment decoder stage.
package clock_pkg;

  localparam int unsigned SECS_PER_DAY  = 86400;
  localparam int unsigned SECS_PER_HOUR = 3600;
  localparam int unsigned SECS_PER_MIN  = 60;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [5:0] digits_t;

  typedef enum logic [2:0] {
    IDLE,
    HOURS,
    MINUTES,
    SPLIT,
    DONE
  } conv_state_t;

  // 24-hour value to 12-hour clock face: 0 -> 12, 13..23 -> 1..11
  function automatic logic [5:0] to_12h(input logic [5:0] h);
    if (h == 6'd0)       return 6'd12;
    else if (h > 6'd12)  return h - 6'd12;
    else                 return h;
  endfunction

endpackage

// File: rtl/time_bcd_converter_if.sv
// Request/result handshake bundle of time_bcd_converter.
interface time_bcd_converter_if #(
  parameter int unsigned SEC_W = 17
);
  import clock_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [SEC_W-1:0] seconds;
  logic             out_valid;
  logic             out_ready;
  digits_t          num;
  logic             err;
  logic             pm;

  modport master (
    output in_valid, seconds, out_ready,
    input  in_ready, out_valid, num, err, pm
  );

  modport slave (
    input  in_valid, seconds, out_ready,
    output in_ready, out_valid, num, err, pm
  );
endinterface

// File: rtl/tens_splitter.sv
// Iterative binary-to-two-digit BCD split by repeated subtraction of 10.
module tens_splitter
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] in,
  output bcd_t       tens,
  output bcd_t       units,
  output logic       done
);

  logic [5:0] val_q, val_d;
  bcd_t       tens_q, tens_d;

  always_comb begin
    val_d  = val_q;
    tens_d = tens_q;
    if (load) begin
      val_d  = in;
      tens_d = '0;
    end else if (val_q >= 6'd10) begin
      val_d  = val_q - 6'd10;
      tens_d = tens_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q  <= '0;
      tens_q <= '0;
    end else begin
      val_q  <= val_d;
      tens_q <= tens_d;
    end
  end

  assign tens  = tens_q;
  assign units = val_q[3:0];
  assign done  = (val_q < 6'd10);

endmodule

// File: rtl/time_bcd_converter.sv
// Seconds-of-day to HH:MM:SS BCD converter using subtractive division.
// Optional macro TWELVE_HOUR_EN: 12-hour hour digits with a PM flag.
module time_bcd_converter
  import clock_pkg::*;
#(
  parameter int unsigned SEC_W       = 17,
  parameter bcd_t        BLANK_DIGIT = 4'hF
) (
  input logic                 clk,
  input logic                 reset,
  time_bcd_converter_if.slave bus
);

  conv_state_t      state_q, state_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic [5:0]       hr_q, hr_d, mn_q, mn_d;
  digits_t          num_q, num_d;
  logic             err_q, err_d, pm_q, pm_d;
  logic             load;
  logic [5:0]       hr_split;
  bcd_t             tens_h, units_h, tens_m, units_m, tens_s, units_s;
  logic             done_h, done_m, done_s;
`ifdef TWELVE_HOUR_EN
  logic             pm_pend_q, pm_pend_d;
`endif

  tens_splitter u_split_h (.clk(clk), .reset(reset), .load(load), .in(hr_split),
                           .tens(tens_h), .units(units_h), .done(done_h));
  tens_splitter u_split_m (.clk(clk), .reset(reset), .load(load), .in(mn_q),
                           .tens(tens_m), .units(units_m), .done(done_m));
  tens_splitter u_split_s (.clk(clk), .reset(reset), .load(load), .in(rem_q[5:0]),
                           .tens(tens_s), .units(units_s), .done(done_s));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      hr_q    <= '0;
      mn_q    <= '0;
      num_q   <= '0;
      err_q   <= 1'b0;
      pm_q    <= 1'b0;
`ifdef TWELVE_HOUR_EN
      pm_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      hr_q    <= hr_d;
      mn_q    <= mn_d;
      num_q   <= num_d;
      err_q   <= err_d;
      pm_q    <= pm_d;
`ifdef TWELVE_HOUR_EN
      pm_pend_q <= pm_pend_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    hr_d    = hr_q;
    mn_d    = mn_q;
    num_d   = num_q;
    err_d   = err_q;
    pm_d    = pm_q;
    load    = 1'b0;
`ifdef TWELVE_HOUR_EN
    pm_pend_d = pm_pend_q;
    hr_split  = to_12h(hr_q);
`else
    hr_split  = hr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          rem_d = bus.seconds;
          hr_d  = '0;
          mn_d  = '0;
          if (bus.seconds >= SEC_W'(SECS_PER_DAY)) begin
            state_d = DONE;
            err_d   = 1'b1;
            pm_d    = 1'b0;
            num_d   = {6{BLANK_DIGIT}};
          end else begin
            state_d = HOURS;
          end
        end
      end
      HOURS: begin
        if (rem_q >= SEC_W'(SECS_PER_HOUR)) begin
          rem_d = rem_q - SEC_W'(SECS_PER_HOUR);
          hr_d  = hr_q + 6'd1;
        end else begin
          state_d = MINUTES;
        end
      end
      MINUTES: begin
        if (rem_q >= SEC_W'(SECS_PER_MIN)) begin
          rem_d = rem_q - SEC_W'(SECS_PER_MIN);
          mn_d  = mn_q + 6'd1;
        end else begin
          state_d = SPLIT;
          load    = 1'b1;
`ifdef TWELVE_HOUR_EN
          // pm is staged so the visible flag only changes with the new digits
          pm_pend_d = (hr_q >= 6'd12);
`endif
        end
      end
      SPLIT: begin
        if (done_h && done_m && done_s) begin
          state_d = DONE;
          num_d   = {tens_h, units_h, tens_m, units_m, tens_s, units_s};
          err_d   = 1'b0;
`ifdef TWELVE_HOUR_EN
          pm_d    = pm_pend_q;
`else
          pm_d    = 1'b0;
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.num       = num_q;
    bus.err       = err_q;
    bus.pm        = pm_q;
  end

endmodule

// File: tb/tb_time_bcd_converter.sv
// Directed scoreboard bench for time_bcd_converter (both TWELVE_HOUR_EN builds).
module tb_time_bcd_converter;
  import clock_pkg::*;

  typedef struct {
    digits_t num;
    logic    err;
    logic    pm;
    int      lat;
  } exp_t;

  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;
  exp_t sb[$];

  time_bcd_converter_if #(.SEC_W(17)) bus ();

  time_bcd_converter #(.SEC_W(17), .BLANK_DIGIT(4'hF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model by true division; lat = edges after the accept edge.
  function automatic exp_t model(input int unsigned s);
    exp_t e;
    int unsigned h, m, sc, hd, t;
    if (s >= 86400) begin
      e.num = {6{4'hF}};
      e.err = 1'b1;
      e.pm  = 1'b0;
      e.lat = 0;
      return e;
    end
    h  = s / 3600;
    m  = (s % 3600) / 60;
    sc = s % 60;
    hd = h;
    e.pm = 1'b0;
`ifdef TWELVE_HOUR_EN
    e.pm = (h >= 12);
    if (h == 0) hd = 12;
    else if (h > 12) hd = h - 12;
`endif
    t = hd / 10;
    if (m / 10 > t) t = m / 10;
    if (sc / 10 > t) t = sc / 10;
    e.num[5] = 4'(hd / 10);
    e.num[4] = 4'(hd % 10);
    e.num[3] = 4'(m / 10);
    e.num[2] = 4'(m % 10);
    e.num[1] = 4'(sc / 10);
    e.num[0] = 4'(sc % 10);
    e.err = 1'b0;
    e.lat = int'(h + m + t + 3);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int unsigned s);
    chk("send_in_ready", 32'(bus.in_ready), 32'd1);
    bus.seconds  = 17'(s);
    bus.in_valid = 1'b1;
    sb.push_back(model(s));
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Called right after an accept edge; waits for out_valid, compares, and
  // completes the handshake when out_ready is high.
  task automatic collect(input string tag);
    int   n;
    logic saw_ready;
    exp_t e;
    n = 0;
    saw_ready = 1'b0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      if (bus.in_ready === 1'b1) saw_ready = 1'b1;
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_busy_in_ready"}, 32'(saw_ready), 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_num"}, 32'(bus.num), 32'(e.num));
      chk({tag, "_err"}, 32'(bus.err), 32'(e.err));
      chk({tag, "_pm"},  32'(bus.pm),  32'(e.pm));
      chk({tag, "_lat"}, 32'(n), 32'(e.lat));
    end
    if (bus.out_ready === 1'b1) begin
      tick();
      chk({tag, "_hs_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_hs_in_ready"},  32'(bus.in_ready),  32'd1);
    end
  endtask

  initial begin
    digits_t held;
    n_run = 0;
    n_fail = 0;
    bus.in_valid  = 1'b0;
    bus.seconds   = '0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);
    chk("rst_pm",        32'(bus.pm),        32'd0);
    chk("rst_num",       32'(bus.num),       32'd0);
    reset = 1'b0;
    tick();

    send(47020);  collect("t13_03_40");
    send(0);      collect("t00_00_00");
    send(86399);  collect("t23_59_59");
    send(86400);  collect("oor_86400");
    send(131071); collect("oor_131071");
    send(3725);   collect("clr_err");

    // result held while the consumer stalls; busy request ignored
    bus.out_ready = 1'b0;
    send(45296);
    collect("hold");
    held = bus.num;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        bus.seconds  = 17'd100;
        bus.in_valid = 1'b1;
      end
      tick();
      bus.in_valid = 1'b0;
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready",  32'(bus.in_ready),  32'd0);
      chk("hold_num",       32'(bus.num),       32'(held));
    end
    bus.out_ready = 1'b1;
    tick();
    chk("rel_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rel_in_ready",  32'(bus.in_ready),  32'd1);
    repeat (5) tick();
    chk("rel_no_ghost", 32'(bus.out_valid), 32'd0);
    chk("rel_num_kept", 32'(bus.num), 32'(held));

    // reset while in MINUTES of a 23:59:59 conversion
    send(86399);
    repeat (30) tick();
    chk("mid_busy", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    tick();
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_num",       32'(bus.num),       32'd0);
    chk("mid_rst_err",       32'(bus.err),       32'd0);
    reset = 1'b0;
    sb.delete();
    tick();
    send(3661);  collect("t01_01_01");
    send(43200); collect("t12_00_00");

    // in_valid held high: second request only taken once back in IDLE
    bus.seconds  = 17'd3599;
    bus.in_valid = 1'b1;
    sb.push_back(model(3599));
    tick();
    bus.seconds = 17'd7322;
    sb.push_back(model(7322));
    collect("b2b_first");
    tick();
    bus.in_valid = 1'b0;
    collect("b2b_second");
    chk("b2b_sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
